jtcontra_rom_arb: RTL

Four-slot SDRAM read arbiter with one-line-per-slot caching. It shares the single SDRAM read port between the two GFX ROM fetchers, the sound CPU ROM and the main CPU ROM. It sits between those requesters and the SDRAM controller. Each slot owns a 32-bit cache line; misses are scheduled round-robin, one outstanding SDRAM transaction at a time.

---
 rtl/jtcontra_rom_arb_if.sv | 26 ++
 rtl/jtcontra_rom_arb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/jtcontra_rom_arb_if.sv
// Bus bundle between the ROM arbiter, its four slot requesters and the SDRAM read port.
interface jtcontra_rom_arb_if;
  logic        downloading;
  logic [3:0]  slot_cs;
  logic [71:0] slot_addr;
  logic [3:0]  slot_ok;
  logic [63:0] slot_dout;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic        refresh_en;

  // Arbiter side
  modport slave (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );

  // Requester / controller side
  modport master (
    output downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );
endinterface

// File: rtl/jtcontra_rom_arb.sv
// Four-slot SDRAM read arbiter; each slot caches one 32-bit line, misses served
// round-robin with a single outstanding SDRAM transaction.
module jtcontra_rom_arb #(
  parameter logic [21:0] OFFSET0 = 22'h0,
  parameter logic [21:0] OFFSET1 = 22'h0,
  parameter logic [21:0] OFFSET2 = 22'h0,
  parameter logic [21:0] OFFSET3 = 22'h0
) (
  input logic               clk,
  input logic               rst_n,
  jtcontra_rom_arb_if.slave bus
);

  localparam logic [3:0][21:0] Offsets = {OFFSET3, OFFSET2, OFFSET1, OFFSET0};

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0][16:0]  tag_q;
  logic [3:0][31:0]  line_q;
  logic [16:0]       tag_pend_q, tag_pend_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        last_q, last_d;
  logic              req_q, req_d;
  logic [21:0]       sdram_addr_q, sdram_addr_d;
  logic [3:0]        slot_ok_q;
  logic [3:0][15:0]  slot_dout_q;

  logic [3:0][17:0]  addr_w;
  logic [3:0]        hit, miss;
  logic [1:0]        win, cand;
  logic              found;
  logic              fill;

  assign addr_w = bus.slot_addr;

  // Per-slot hit/miss against the cached tag
  always_comb begin
    hit  = '0;
    miss = '0;
    for (int n = 0; n < 4; n++) begin
      hit[n]  = valid_q[n] && (tag_q[n] == addr_w[n][17:1]);
      miss[n] = bus.slot_cs[n] & ~hit[n] & ~bus.downloading;
    end
  end

  // Round-robin pick: first miss after the last granted slot
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && miss[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Transaction FSM next state
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    sdram_addr_d = sdram_addr_q;
    gnt_d        = gnt_q;
    tag_pend_d   = tag_pend_q;
    last_d       = last_q;
    fill         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d        = win;
          tag_pend_d   = addr_w[win][17:1];
          sdram_addr_d = Offsets[win] + {4'd0, addr_w[win][17:1], 1'b0};
          last_d       = win;
          req_d        = 1'b1;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (bus.sdram_ack) begin
          req_d   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.data_rdy) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Valid bits: cleared throughout a download, so a fill landing then is dropped
  always_comb begin
    valid_d = valid_q;
    if (fill) valid_d[gnt_q] = 1'b1;
    if (bus.downloading) valid_d = '0;
  end

  // FSM, request and cache state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      sdram_addr_q <= '0;
      gnt_q        <= '0;
      tag_pend_q   <= '0;
      last_q       <= 2'd3;
      valid_q      <= '0;
      tag_q        <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      sdram_addr_q <= sdram_addr_d;
      gnt_q        <= gnt_d;
      tag_pend_q   <= tag_pend_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      if (fill) begin
        line_q[gnt_q] <= bus.data_read;
        tag_q[gnt_q]  <= tag_pend_q;
      end
    end
  end

  // Registered per-slot data and ok flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_ok_q   <= '0;
      slot_dout_q <= '0;
    end else begin
      slot_ok_q <= bus.slot_cs & hit & {4{~bus.downloading}};
      for (int n = 0; n < 4; n++) begin
        slot_dout_q[n] <= addr_w[n][0] ? line_q[n][31:16] : line_q[n][15:0];
      end
    end
  end

  assign bus.slot_ok    = slot_ok_q;
  assign bus.slot_dout  = slot_dout_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = sdram_addr_q;
  assign bus.refresh_en = (state_q == StIdle) && (miss == 4'd0);

endmodule
